// File: rtl/uart_pkg.sv
// Shared constants and types for the UART baud/tick generator.
package uart_pkg;

  // Default prescaler width and oversampling ratio.
  localparam int CNT_W      = 16;
  localparam int OVERSAMPLE = 16;

  // Divisors for a 50 MHz clk_in with 16x oversampling.
  // Each value is rounded to the nearest integer:
  // 50e6 / (16 * 9600)   - 1 = 324.5 -> 325
  // 50e6 / (16 * 115200) - 1 =  26.1 ->  26
  localparam int DIV_9600   = 325;
  localparam int DIV_115200 = 26;

  // Registered tick bundle presented to the framing datapaths.
  typedef struct packed {
    logic os;   // oversample tick
    logic bnd;  // bit boundary tick
    logic mid;  // bit centre tick
  } tick_t;

  // Ceiling log2. Returns at least 1, so a 1-entry counter still has a bit.
  function automatic int clog2(input int unsigned v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// Control/tick bundle between the baud generator and the UART datapaths.
interface baud_tick_gen_if #(
  parameter int CNT_W = uart_pkg::CNT_W
) ();

  logic             en;
  logic             sync;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             div_ack;
  logic             os_tick;
  logic             bit_tick;
  logic             mid_tick;
  logic             clk_out;

  // Controller side: programs the divisor and consumes ticks.
  modport master (
    output en, sync, div_in, div_load,
    input  div_ack, os_tick, bit_tick, mid_tick, clk_out
  );

  // Generator side.
  modport slave (
    input  en, sync, div_in, div_load,
    output div_ack, os_tick, bit_tick, mid_tick, clk_out
  );

endinterface

// File: rtl/tick_prescaler.sv
// Programmable prescaler: counts 0..div_active and flags the terminal
// cycle. Divisor changes are staged and only take effect when the count
// restarts (wrap/sync) or is frozen (en=0), so no period is ever truncated.
module tick_prescaler #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 325
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] pre_cnt;
  logic [CNT_W-1:0] div_active;
  logic [CNT_W-1:0] div_pending;
  logic             pend_valid;
  logic             apply;

  // Terminal count only counts while running; sync has priority.
  assign wrap  = en && !sync && (pre_cnt == div_active);

  // Safe points to swap the divisor: count restarting or frozen.
  assign apply = pend_valid && (wrap || sync || !en);

  // Prescaler count. The >= compare also covers re-enable after a
  // divisor shrink while frozen: an out-of-range count restarts at 0
  // without producing a wrap.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)
      pre_cnt <= '0;
    else if (sync)
      pre_cnt <= '0;
    else if (en)
      pre_cnt <= (pre_cnt >= div_active) ? '0 : pre_cnt + ONE;
  end

  // Divisor staging. A load coinciding with an apply leaves the new value
  // pending while the older one goes live.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      div_active  <= DIV_RST;
      div_pending <= '0;
      pend_valid  <= 1'b0;
      div_ack     <= 1'b0;
    end else begin
      div_ack <= apply;
      if (apply)
        div_active <= div_pending;
      if (div_load) begin
        div_pending <= div_in;
        pend_valid  <= 1'b1;
      end else if (apply) begin
        pend_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: single-cycle enables for UART RX/TX framing plus a
// 50% duty baud square wave. Everything is on clk_in.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CNT_W       = uart_pkg::CNT_W,
  parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE,
  parameter int DEFAULT_DIV = DIV_9600
) (
  input  logic            clk_in,
  input  logic            rst,
  baud_tick_gen_if.slave  bus
);

  localparam int              OS_W   = clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_TOP = OS_W'(OVERSAMPLE - 1);
  // os_cnt value whose wrap lands on the bit centre.
  localparam logic [OS_W-1:0] OS_PRE_MID = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_ONE = OS_W'(1);

  logic            wrap;
  logic [OS_W-1:0] os_cnt;
  tick_t           tick_q;
  logic            clk_q;
  logic            at_top;
  logic            at_pre_mid;

  tick_prescaler #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_pre (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (bus.en),
    .sync     (bus.sync),
    .div_in   (bus.div_in),
    .div_load (bus.div_load),
    .div_ack  (bus.div_ack),
    .wrap     (wrap)
  );

  assign at_top     = (os_cnt == OS_TOP);
  assign at_pre_mid = (os_cnt == OS_PRE_MID);

  // Oversample position within the bit; explicit wrap so non power-of-two
  // ratios work.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)
      os_cnt <= '0;
    else if (bus.sync)
      os_cnt <= '0;
    else if (wrap)
      os_cnt <= at_top ? '0 : os_cnt + OS_ONE;
  end

  // Registered ticks; wrap already folds in en and sync, so freezes and
  // restarts suppress the next cycle's ticks.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      tick_q <= '0;
    end else begin
      tick_q.os  <= wrap;
      tick_q.bnd <= wrap && at_top;
      tick_q.mid <= wrap && at_pre_mid;
    end
  end

  // Square wave: high from bit boundary to bit centre.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)
      clk_q <= 1'b0;
    else if (bus.sync)
      clk_q <= 1'b0;
    else if (wrap && at_top)
      clk_q <= 1'b1;
    else if (wrap && at_pre_mid)
      clk_q <= 1'b0;
  end

  assign bus.os_tick  = tick_q.os;
  assign bus.bit_tick = tick_q.bnd;
  assign bus.mid_tick = tick_q.mid;
  assign bus.clk_out  = clk_q;

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised successor to the fixed-ratio UART clock divider.
- Runtime-programmable divisor, applied glitch-free.
- Produces single-cycle enable ticks instead of a derived clock: oversample tick for RX, bit tick and mid-bit tick for TX/RX framing.
- Also produces an optional 50%-duty baud-rate square wave for debug/legacy.
- Sits between the system clock and the uart_tx/uart_rx datapaths. Everything runs on clk_in; no derived clock domains.

Parameters:
- CNT_W, 16: width of the prescaler counter and divisor.
- OVERSAMPLE, 16: oversample ticks per bit. Even, ≥ 4.
- DEFAULT_DIV, 325: divisor loaded at reset. os_tick period = DEFAULT_DIV+1 clk_in cycles.

Ports:
- clk_in, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- en, in, 1: count enable. Low freezes all counters.
- sync, in, 1: synchronous phase restart (RX start-bit alignment).
- div_in, in, CNT_W: new divisor value.
- div_load, in, 1: 1-cycle request to load div_in.
- div_ack, out, 1: 1-cycle pulse when a pending divisor becomes active.
- os_tick, out, 1: oversample tick, 1 cycle wide.
- bit_tick, out, 1: tick at bit boundary (os_cnt wrap).
- mid_tick, out, 1: tick at bit centre (os_cnt reaching OVERSAMPLE/2).
- clk_out, out, 1: 50% duty baud square wave.

Behaviour:
- Reset (rst=0, async):
  - pre_cnt=0, os_cnt=0.
  - div_active=DEFAULT_DIV, div_pending=0, pend_valid=0.
  - All outputs 0.
- Prescaler:
  - While en=1 and sync=0: pre_cnt increments each cycle.
  - wrap = (pre_cnt==div_active). On wrap, pre_cnt<=0.
  - div_active=D gives a wrap every D+1 cycles. D=0 gives a wrap every cycle.
- Outputs are registered:
  - os_tick=1 in the cycle after wrap.
  - Example: D=3, en rises with pre_cnt=0 at cycle 0 → os_tick high in cycles 4, 8, 12, ...
- os_cnt (log2(OVERSAMPLE) bits):
  - Increments on wrap; wraps OVERSAMPLE-1→0.
  - bit_tick=1 together with the os_tick whose wrap takes os_cnt from OVERSAMPLE-1 to 0.
  - mid_tick=1 together with the os_tick whose wrap takes os_cnt to OVERSAMPLE/2.
  - Bit period = (D+1)*OVERSAMPLE cycles.
- clk_out:
  - Set to 1 with each bit_tick; cleared to 0 with each mid_tick.
  - First rising edge coincides with the first bit_tick after reset/sync.
- en=0:
  - pre_cnt and os_cnt hold.
  - os_tick, bit_tick and mid_tick are 0 the next cycle; clk_out holds.
  - Re-enable resumes the count without restarting it.
- sync=1 (priority over wrap and en):
  - pre_cnt<=0, os_cnt<=0, clk_out<=0.
  - No ticks in the following cycle.
  - The first os_tick after sync deasserts arrives D+1 cycles later.
- Divisor update:
  - div_load=1: div_pending<=div_in, pend_valid<=1.
  - A second load while pending overwrites the value. Only one div_ack is produced.
  - Apply condition, checked from the cycle after the load: wrap, sync, or en=0.
  - On apply: div_active<=div_pending, pend_valid<=0, div_ack=1 the next cycle.
  - Because apply happens only when pre_cnt restarts or is frozen at a value, pre_cnt never exceeds the new div_active except in the en=0 case. There, on re-enable, if pre_cnt > div_active then pre_cnt<=0 and no tick is issued.
  - div_load in the same cycle as an apply: the previously pending value is applied and acked; the new div_in becomes pending.
- Reset mid-operation: all state returns immediately to reset values and any pending load is discarded.

Decomposition:
- uart_pkg holds:
  - CNT_W, OVERSAMPLE.
  - Precomputed divisors for a 50 MHz clock: DIV_9600=325, DIV_115200=26.
  - Function clog2 for os_cnt width.
- One sub-module, tick_prescaler:
  - Contains pre_cnt, the wrap compare, and the div_active/div_pending/pend_valid/div_ack logic.
  - Outputs wrap.
- baud_tick_gen itself holds os_cnt, the tick registers and clk_out.

Test Plan:
Bench configuration: OVERSAMPLE=4, DEFAULT_DIV=3.
1. Release reset, en=1 → os_tick at cycles 4, 8, 12, 16. bit_tick at cycle 16. mid_tick at cycle 8. clk_out rises at 16, falls at 24, period 16 cycles.
2. div_load with div_in=1 at cycle 5 → div_ack in the cycle after the wrap at cycle 7. Subsequent os_tick every 2 cycles: 8, 10, 12, ...
3. en low for 7 cycles mid-count → no ticks during the gap. Tick spacing resumes exactly as it was before the pause.
4. sync pulse with os_cnt=2 → all ticks suppressed, clk_out=0. os_tick 4 cycles after sync deasserts. bit_tick on the 4th os_tick after that.
5. div_in=0 loaded → os_tick continuously high, bit_tick every 4 cycles. Then load 5 with en=0 (pre_cnt frozen at 0) → applied and acked immediately; period 6 after re-enable.
6. Assert rst mid-bit with a load pending → all outputs 0 asynchronously. After release, period reverts to DEFAULT_DIV (4 cycles) and no div_ack is issued.
